// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Request/result bundle for the bit-serial subtractor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : LSB-first bit-serial a - b - bin, one bit per clock, done pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  wire logic           clk,
   input  wire logic           reset_n,
   serial_subtractor_if.slave  bus
);
   localparam int c_CW = $clog2(WIDTH);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_br;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_res;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic             w_a0;
   logic             w_b0;
   logic             w_d;
   logic             w_br_next;
   logic [WIDTH-1:0] w_res_next;

   assign w_a0       = r_a[0];
   assign w_b0       = r_b[0];
   assign w_d        = w_a0 ^ w_b0 ^ r_br;
   assign w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   // busy/done are set alongside the state so they stay pure flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_br    <= bus.bin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_br  <= w_br_next;
               r_res <= w_res_next;
               r_cnt <= r_cnt + c_CW'(1);
               if (r_cnt == c_CNT_LAST) begin
                  r_diff  <= w_res_next;
                  r_bout  <= w_br_next;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.diff = r_diff;
   assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Queue-scoreboard bench for serial_subtractor at WIDTH=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
   localparam int c_W = 4;

   logic clk;
   logic reset_n;
   int   tests;
   int   fails;
   int   cyc;
   logic [c_W:0] exp_q[$];

   serial_subtractor_if #(.WIDTH(c_W)) bus ();

   serial_subtractor #(.WIDTH(c_W)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Scoreboard monitor: every done must match the oldest outstanding result.
   always @(negedge clk) begin
      if (reset_n && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            logic [c_W:0] e;
            e = exp_q.pop_front();
            check("diff", int'(bus.diff), int'(e[c_W-1:0]));
            check("bout", int'(bus.bout), int'(e[c_W]));
         end
      end
   end

   task automatic wait_idle_negedge();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("idle_timeout", 1, 0);
   endtask

   // Issue one op with a hand-computed result; operands are scrambled after acceptance.
   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] ed, input logic eb);
      wait_idle_negedge();
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      exp_q.push_back({eb, ed});
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.bin   = ~bin;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) check("drain_timeout", 1, 0);
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      int last_cyc;
      logic [4:0] m;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      reset_n   = 1'b0;
      #12;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_diff", int'(bus.diff), 0);
      check("rst_bout", int'(bus.bout), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // 5 - 3 with busy-length measurement.
      issue(4'd5, 4'd3, 1'b0, 4'b0010, 1'b0);
      busy_cnt = 1;
      for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
      end
      check("busy_cycles", busy_cnt, 5);
      drain();

      issue(4'd3,  4'd5,  1'b0, 4'b1110, 1'b1);
      issue(4'd0,  4'd0,  1'b1, 4'b1111, 1'b1);
      issue(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1);
      issue(4'd15, 4'd0,  1'b0, 4'b1111, 1'b0);
      drain();

      // A second start during SHIFT must be dropped.
      issue(4'd9, 4'd2, 1'b0, 4'b0111, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd1;
      bus.b     = 4'd1;
      bus.bin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      check("diff_held_idle", int'(bus.diff), 7);

      // Abort in the second SHIFT cycle; no result is queued for it.
      wait_idle_negedge();
      bus.start = 1'b1;
      bus.a     = 4'd12;
      bus.b     = 4'd3;
      bus.bin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      check("abort_diff", int'(bus.diff), 0);
      check("abort_bout", int'(bus.bout), 0);
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      bus.start = 1'b1;
      bus.a     = 4'd8;
      bus.b     = 4'd1;
      bus.bin   = 1'b0;
      exp_q.push_back({1'b0, 4'b0111});
      @(posedge clk);
      #1;
      check("first_start_after_rst", int'(bus.busy), 1);
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Exhaustive sweep with start held high.
      last_cyc = 0;
      for (int i = 0; i < 512; i++) begin
         wait_idle_negedge();
         bus.start = 1'b1;
         bus.a     = 4'(i >> 5);
         bus.b     = 4'(i >> 1);
         bus.bin   = i[0];
         m = 5'd16 + {1'b0, bus.a} - {1'b0, bus.b} - {4'd0, bus.bin};
         exp_q.push_back({~m[4], m[3:0]});
         if (i > 0) check("b2b_spacing", cyc - last_cyc, 6);
         last_cyc = cyc;
      end
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      check("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
